// File: rtl/cnn_bias_act_pkg.sv
// Shared CNN core parameters and state encoding for the bias/activation stage.
package cnn_bias_act_pkg;

  localparam int OX       = 4;
  localparam int OY       = 4;
  localparam int DATA_LEN = 20;
  localparam int B_LEN    = 8;
  localparam int OUT_LEN  = 8;

  localparam int N_ELEM = OX * OY;
  localparam int CNT_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cnn_bias_relu_sat.sv
// One-element bias add, optional ReLU and signed saturation (combinational).
// ReLU clamping of negative sums is enabled by defining CNN_RELU_EN.
module cnn_bias_relu_sat
  import cnn_bias_act_pkg::*;
(
  input  logic [DATA_LEN-1:0] acc,
  input  logic [B_LEN-1:0]    bias,
  output logic [OUT_LEN-1:0]  out
);

  localparam logic signed [DATA_LEN:0] SAT_MAX = (DATA_LEN+1)'((2 ** (OUT_LEN - 1)) - 1);
  localparam logic signed [DATA_LEN:0] SAT_MIN = -SAT_MAX - (DATA_LEN+1)'(1);

  logic signed [DATA_LEN:0] sum;

  // One guard bit makes the add overflow-free since B_LEN <= DATA_LEN.
  assign sum = $signed({acc[DATA_LEN-1], acc})
             + $signed({{(DATA_LEN + 1 - B_LEN){bias[B_LEN-1]}}, bias});

  always_comb begin
    out = sum[OUT_LEN-1:0];
    if (sum > SAT_MAX) begin
      out = SAT_MAX[OUT_LEN-1:0];
    end
`ifdef CNN_RELU_EN
    else if (sum < 0) begin
      out = '0;
    end
`else
    else if (sum < SAT_MIN) begin
      out = SAT_MIN[OUT_LEN-1:0];
    end
`endif
  end

endmodule

// File: rtl/cnn_bias_act.sv
// Bias + activation stage: captures one output-channel map, processes one element per
// cycle through a shared cnn_bias_relu_sat, and hands the packed map out under valid/ready.
module cnn_bias_act
  import cnn_bias_act_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_soft_reset,
  input  logic                         i_in_valid,
  input  logic [OX*OY*DATA_LEN-1:0]    i_in_ci_acc,
  input  logic [B_LEN-1:0]             i_bias,
  output logic                         o_in_ready,
  output logic                         o_ot_valid,
  input  logic                         i_ot_ready,
  output logic [OX*OY*OUT_LEN-1:0]     o_ot_fmap,
  output logic                         o_drop
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ELEM - 1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [OX*OY*DATA_LEN-1:0]   acc_q, acc_d;
  logic [B_LEN-1:0]            bias_q, bias_d;
  logic [OX*OY*OUT_LEN-1:0]    fmap_q, fmap_d;
  logic                        drop_q, drop_d;
  logic                        in_ready_q, in_ready_d;
  logic                        ot_valid_q, ot_valid_d;
  logic [DATA_LEN-1:0]         acc_sel;
  logic [OUT_LEN-1:0]          elem_res;

  assign acc_sel = acc_q[cnt_q*DATA_LEN +: DATA_LEN];

  cnn_bias_relu_sat u_relu_sat (
    .acc  (acc_sel),
    .bias (bias_q),
    .out  (elem_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_soft_reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (i_in_valid) state_d = ST_RUN;
        ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
        ST_DONE: if (i_ot_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    fmap_d     = fmap_q;
    drop_d     = drop_q;
    // Handshake flags are registered decodes of the next state, so no comb path from i_ot_ready.
    in_ready_d = (state_d == ST_IDLE);
    ot_valid_d = (state_d == ST_DONE);
    if (i_soft_reset) begin
      cnt_d  = '0;
      acc_d  = '0;
      bias_d = '0;
      fmap_d = '0;
      drop_d = 1'b0;
    end else begin
      if (i_in_valid && !in_ready_q) begin
        drop_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (i_in_valid) begin
            acc_d  = i_in_ci_acc;
            bias_d = i_bias;
            cnt_d  = '0;
          end
        end
        ST_RUN: begin
          fmap_d[cnt_q*OUT_LEN +: OUT_LEN] = elem_res;
          cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      bias_q     <= '0;
      fmap_q     <= '0;
      drop_q     <= 1'b0;
      in_ready_q <= 1'b1;
      ot_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      fmap_q     <= fmap_d;
      drop_q     <= drop_d;
      in_ready_q <= in_ready_d;
      ot_valid_q <= ot_valid_d;
    end
  end

  assign o_in_ready = in_ready_q;
  assign o_ot_valid = ot_valid_q;
  assign o_ot_fmap  = fmap_q;
  assign o_drop     = drop_q;

endmodule

// File: tb/tb_cnn_bias_act.sv
// Directed self-checking bench for cnn_bias_act; expectations follow CNN_RELU_EN.
module tb_cnn_bias_act;
  import cnn_bias_act_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic                       i_soft_reset = 1'b0;
  logic                       i_in_valid = 1'b0;
  logic [OX*OY*DATA_LEN-1:0]  i_in_ci_acc = '0;
  logic [B_LEN-1:0]           i_bias = '0;
  logic                       o_in_ready;
  logic                       o_ot_valid;
  logic                       i_ot_ready = 1'b0;
  logic [OX*OY*OUT_LEN-1:0]   o_ot_fmap;
  logic                       o_drop;

  int tests = 0;
  int fails = 0;

`ifdef CNN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  cnn_bias_act dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_soft_reset(i_soft_reset),
    .i_in_valid  (i_in_valid),
    .i_in_ci_acc (i_in_ci_acc),
    .i_bias      (i_bias),
    .o_in_ready  (o_in_ready),
    .o_ot_valid  (o_ot_valid),
    .i_ot_ready  (i_ot_ready),
    .o_ot_fmap   (o_ot_fmap),
    .o_drop      (o_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OX*OY*OUT_LEN-1:0] model(input int acc[16], input int bias);
    logic [OX*OY*OUT_LEN-1:0] v;
    int s;
    v = '0;
    for (int e = 0; e < 16; e++) begin
      s = acc[e] + bias;
      if (RELU && s < 0) s = 0;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      v[e*OUT_LEN +: OUT_LEN] = OUT_LEN'(s);
    end
    return v;
  endfunction

  task automatic drive(input int acc[16], input int bias);
    for (int e = 0; e < 16; e++) i_in_ci_acc[e*DATA_LEN +: DATA_LEN] = DATA_LEN'(acc[e]);
    i_bias = B_LEN'(bias);
  endtask

  // Pulses valid for one edge (the capture edge).
  task automatic send(input int acc[16], input int bias);
    drive(acc, bias);
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_ot_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!o_ot_valid) begin
      tests++; fails++;
      $display("FAIL wait_done: o_ot_valid=%0b after %0d cycles, required 1", o_ot_valid, lat);
    end
  endtask

  task automatic accept();
    i_ot_ready = 1'b1;
    tick();
    i_ot_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    tests++; if (o_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", o_in_ready); end
    tests++; if (o_ot_valid !== 1'b0) begin fails++; $display("FAIL reset_ot_valid: got %0b want 0", o_ot_valid); end
    tests++; if (o_ot_fmap !== '0) begin fails++; $display("FAIL reset_fmap: got %h want 0", o_ot_fmap); end
    tests++; if (o_drop !== 1'b0) begin fails++; $display("FAIL reset_drop: got %0b want 0", o_drop); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int acc[16];
    int lat;
    logic [OX*OY*OUT_LEN-1:0] exp_v;
    for (int e = 0; e < 16; e++) acc[e] = 10;
    exp_v = {16{8'd7}};
    send(acc, -3);
    tests++; if (o_in_ready !== 1'b0) begin fails++; $display("FAIL basic_busy: in_ready got %0b want 0", o_in_ready); end
    wait_done(lat);
    tests++; if (lat != 16) begin fails++; $display("FAIL basic_latency: got %0d want 16", lat); end
    tests++; if (o_ot_fmap !== exp_v) begin fails++; $display("FAIL basic_fmap: got %h want %h", o_ot_fmap, exp_v); end
    accept();
    tests++; if (o_ot_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      fails++; $display("FAIL basic_handoff: valid=%0b ready=%0b want 0/1", o_ot_valid, o_in_ready);
    end
  endtask

  task automatic test_saturation();
    int acc[16];
    int lat;
    logic [OX*OY*OUT_LEN-1:0] exp_v;
    for (int e = 0; e < 16; e++) acc[e] = 0;
    acc[0] = 1000;
    acc[1] = -1000;
    exp_v = '0;
    exp_v[7:0]  = 8'd127;
    exp_v[15:8] = RELU ? 8'h00 : 8'h80;
    send(acc, 0);
    wait_done(lat);
    tests++; if (o_ot_fmap !== exp_v) begin fails++; $display("FAIL sat_fmap: got %h want %h", o_ot_fmap, exp_v); end
    accept();
  endtask

  task automatic test_bias_sext();
    int acc[16];
    int lat;
    logic [OX*OY*OUT_LEN-1:0] exp_v;
    for (int e = 0; e < 16; e++) acc[e] = 0;
    exp_v = RELU ? '0 : {16{8'h80}};
    send(acc, -128);
    wait_done(lat);
    tests++; if (o_ot_fmap !== exp_v) begin fails++; $display("FAIL sext_neg128: got %h want %h", o_ot_fmap, exp_v); end
    accept();
    for (int e = 0; e < 16; e++) acc[e] = -5;
    exp_v = RELU ? '0 : {16{8'hFF}};
    send(acc, 4);
    wait_done(lat);
    tests++; if (o_ot_fmap !== exp_v) begin fails++; $display("FAIL sext_minus1: got %h want %h", o_ot_fmap, exp_v); end
    accept();
  endtask

  task automatic test_backpressure();
    int acc[16];
    int acc2[16];
    int lat;
    logic [OX*OY*OUT_LEN-1:0] exp_v;
    for (int e = 0; e < 16; e++) begin
      acc[e]  = e * 20 - 60;
      acc2[e] = 33;
    end
    exp_v = model(acc, 2);
    send(acc, 2);
    wait_done(lat);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        drive(acc2, 1);
        i_in_valid = 1'b1;
      end
      tick();
      i_in_valid = 1'b0;
      tests++; if (o_ot_valid !== 1'b1 || o_ot_fmap !== exp_v) begin
        fails++; $display("FAIL bp_stable c%0d: valid=%0b fmap=%h want 1 %h", c, o_ot_valid, o_ot_fmap, exp_v);
      end
    end
    tests++; if (o_drop !== 1'b1) begin fails++; $display("FAIL bp_drop: got %0b want 1", o_drop); end
    accept();
    tests++; if (o_in_ready !== 1'b1 || o_ot_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: ready=%0b valid=%0b want 1/0", o_in_ready, o_ot_valid);
    end
    tests++; if (o_drop !== 1'b1) begin fails++; $display("FAIL bp_drop_sticky: got %0b want 1", o_drop); end
  endtask

  task automatic test_handoff_drop();
    int acc[16];
    int lat;
    for (int e = 0; e < 16; e++) acc[e] = e;
    i_ot_ready = 1'b1;
    send(acc, 0);
    wait_done(lat);
    tests++; if (lat != 16) begin fails++; $display("FAIL early_ready_latency: got %0d want 16", lat); end
    // Valid arrives on the same edge that leaves DONE: must be dropped.
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
    i_ot_ready = 1'b0;
    tests++; if (o_ot_valid !== 1'b0 || o_in_ready !== 1'b1 || o_drop !== 1'b1) begin
      fails++; $display("FAIL handoff_drop: valid=%0b ready=%0b drop=%0b want 0/1/1", o_ot_valid, o_in_ready, o_drop);
    end
    tick();
    tests++; if (o_in_ready !== 1'b1) begin fails++; $display("FAIL handoff_ignored: ready=%0b want 1", o_in_ready); end
  endtask

  task automatic test_soft_reset();
    int acc[16];
    int lat;
    for (int e = 0; e < 16; e++) acc[e] = 50;
    send(acc, 0);
    repeat (5) tick();
    i_soft_reset = 1'b1;
    i_in_valid = 1'b1;
    tick();
    i_soft_reset = 1'b0;
    i_in_valid = 1'b0;
    tests++; if (o_in_ready !== 1'b1 || o_ot_valid !== 1'b0 || o_ot_fmap !== '0 || o_drop !== 1'b0) begin
      fails++; $display("FAIL soft_reset: ready=%0b valid=%0b fmap=%h drop=%0b want 1/0/0/0", o_in_ready, o_ot_valid, o_ot_fmap, o_drop);
    end
    for (int e = 0; e < 16; e++) acc[e] = 10;
    send(acc, -3);
    wait_done(lat);
    tests++; if (lat != 16 || o_ot_fmap !== {16{8'd7}}) begin
      fails++; $display("FAIL soft_reset_rerun: lat=%0d fmap=%h want 16 %h", lat, o_ot_fmap, {16{8'd7}});
    end
    accept();
  endtask

  task automatic test_async_reset();
    int acc[16];
    int lat;
    for (int e = 0; e < 16; e++) acc[e] = -200;
    send(acc, 0);
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
    repeat (4) tick();
    tests++; if (o_drop !== 1'b1) begin fails++; $display("FAIL async_pre_drop: got %0b want 1", o_drop); end
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if (o_in_ready !== 1'b1 || o_ot_valid !== 1'b0 || o_ot_fmap !== '0 || o_drop !== 1'b0) begin
      fails++; $display("FAIL async_reset: ready=%0b valid=%0b fmap=%h drop=%0b want 1/0/0/0", o_in_ready, o_ot_valid, o_ot_fmap, o_drop);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int e = 0; e < 16; e++) acc[e] = e * 10;
    send(acc, 5);
    wait_done(lat);
    tests++; if (lat != 16 || o_ot_fmap !== model(acc, 5)) begin
      fails++; $display("FAIL async_rerun: lat=%0d fmap=%h want 16 %h", lat, o_ot_fmap, model(acc, 5));
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_bias_sext();
    test_backpressure();
    test_handoff_drop();
    test_soft_reset();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
